// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the memory-response wormhole scheduler and its encoders.
`ifndef BP_ME_WH_PKT_LEN
`define BP_ME_WH_PKT_LEN(pkt_mp, cord_width_mp, len_width_mp) \
    pkt_mp[cord_width_mp +: len_width_mp]
`endif

package bp_me_pkg;

    typedef enum logic [0:0] {
        e_idle,
        e_send
    } bp_me_wormhole_sched_state_e;

    // Highest flit index a packet of the given width can occupy on the link.
    function automatic int unsigned bp_me_max_len(input int unsigned packet_width,
                                                  input int unsigned flit_width);
        return (packet_width + flit_width - 1) / flit_width - 1;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: priority starts just above the last accepted grant.
module bsg_arb_round_robin #(
    parameter int unsigned width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o,
    input  logic               yumi_i
);
    localparam int unsigned idx_width_lp = (width_p > 1) ? $clog2(width_p) : 1;

    logic [idx_width_lp-1:0] last_r;
    logic [idx_width_lp-1:0] w_grant_idx;
    logic                    w_found;

    always_comb begin
        grants_o    = '0;
        w_grant_idx = last_r;
        w_found     = 1'b0;
        // Requesters above last_r win first; otherwise wrap around from index 0.
        for (int i = 0; i < int'(width_p); i++) begin
            if (!w_found && reqs_i[i] && (idx_width_lp'(i) > last_r)) begin
                w_found     = 1'b1;
                grants_o[i] = 1'b1;
                w_grant_idx = idx_width_lp'(i);
            end
        end
        for (int i = 0; i < int'(width_p); i++) begin
            if (!w_found && reqs_i[i]) begin
                w_found     = 1'b1;
                grants_o[i] = 1'b1;
                w_grant_idx = idx_width_lp'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_r <= idx_width_lp'(width_p - 1);
        end else if (yumi_i && w_found) begin
            last_r <= w_grant_idx;
        end
    end

endmodule

// File: rtl/bp_me_wormhole_mem_resp_sched.sv
// Arbitrates encoded mem_resp wormhole packets from several sources onto one link,
// streaming each granted packet as len+1 flits, LSB flit first.
module bp_me_wormhole_mem_resp_sched
    import bp_me_pkg::*;
#(
    parameter int unsigned num_req_p      = 2,
    parameter int unsigned flit_width_p   = 64,
    parameter int unsigned cord_width_p   = 7,
    parameter int unsigned len_width_p    = 4,
    parameter int unsigned packet_width_p = 256
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p*packet_width_p-1:0] packet_i,
    input  logic [num_req_p-1:0]                v_i,
    output logic [num_req_p-1:0]                ready_o,
    output logic [flit_width_p-1:0]             link_data_o,
    output logic                                link_v_o,
    input  logic                                link_ready_i,
    output logic                                len_err_o
);
    localparam int unsigned max_len_lp   = bp_me_max_len(packet_width_p, flit_width_p);
    localparam int unsigned pad_width_lp = (max_len_lp + 1) * flit_width_p;
    localparam logic [len_width_p-1:0] max_len_l = len_width_p'(max_len_lp);

    bp_me_wormhole_sched_state_e state_r;
    logic [packet_width_p-1:0]   pkt_r;
    logic [len_width_p-1:0]      len_r;
    logic [len_width_p-1:0]      flit_cnt_r;
    logic                        len_err_r;

    logic                        w_win;
    logic                        w_accept;
    logic [num_req_p-1:0]        w_grants;
    logic [packet_width_p-1:0]   w_pkt_sel;
    logic [len_width_p-1:0]      w_len_in;
    logic                        w_len_over;
    logic [pad_width_lp-1:0]     w_pkt_pad;

    // Reset is folded in so ready_o stays low while reset is held.
    assign w_win = reset_n_i &&
                   ((state_r == e_idle) ||
                    (link_ready_i && (flit_cnt_r == len_r)));
    assign w_accept = w_win && (|v_i);

    bsg_arb_round_robin #(
        .width_p (num_req_p)
    ) u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .reqs_i    (v_i & {num_req_p{w_win}}),
        .grants_o  (w_grants),
        .yumi_i    (w_accept)
    );

    assign ready_o = w_grants;

    always_comb begin
        w_pkt_sel = '0;
        for (int i = 0; i < int'(num_req_p); i++) begin
            if (w_grants[i]) begin
                w_pkt_sel = w_pkt_sel | packet_i[i*packet_width_p +: packet_width_p];
            end
        end
    end

    assign w_len_in   = `BP_ME_WH_PKT_LEN(w_pkt_sel, cord_width_p, len_width_p);
    assign w_len_over = (w_len_in > max_len_l);

    always_comb begin
        w_pkt_pad                     = '0;
        w_pkt_pad[packet_width_p-1:0] = pkt_r;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_idle;
            pkt_r      <= '0;
            len_r      <= '0;
            flit_cnt_r <= '0;
            len_err_r  <= 1'b0;
        end else if (w_win) begin
            flit_cnt_r <= '0;
            if (w_accept) begin
                state_r <= e_send;
                pkt_r   <= w_pkt_sel;
                len_r   <= w_len_over ? max_len_l : w_len_in;
                if (w_len_over) begin
                    len_err_r <= 1'b1;
                end
            end else begin
                state_r <= e_idle;
            end
        end else if ((state_r == e_send) && link_ready_i) begin
            flit_cnt_r <= flit_cnt_r + 1'b1;
        end
    end

    assign link_v_o    = (state_r == e_send);
    assign link_data_o = w_pkt_pad[32'(flit_cnt_r) * flit_width_p +: flit_width_p];
    assign len_err_o   = len_err_r;

endmodule

// File: tb/tb_bp_me_wormhole_mem_resp_sched.sv
// Bench for the mem_resp wormhole scheduler: directed vector table, reset corner, random run.
module tb_bp_me_wormhole_mem_resp_sched;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [511:0] packet_i = '0;
    logic [1:0]   v_i = '0;
    logic [1:0]   ready_o;
    logic [63:0]  link_data_o;
    logic         link_v_o;
    logic         link_ready_i = 1'b0;
    logic         len_err_o;

    always #5 clk = ~clk;

    bp_me_wormhole_mem_resp_sched dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .packet_i     (packet_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .link_data_o  (link_data_o),
        .link_v_o     (link_v_o),
        .link_ready_i (link_ready_i),
        .len_err_o    (len_err_o)
    );

    int checks = 0;
    int errors = 0;

    logic [255:0] base0, base1, pk0, pk1;

    // Reference model: queue of flits still owed on the link.
    logic [63:0] m_q[$];
    int          m_last;
    bit          m_err;

    typedef struct {
        bit         rst;
        logic [1:0] v;
        logic       lr;
        logic [3:0] len0, len1;
        logic [1:0] e_ready;
        logic       e_v;
        int         e_src;
        int         e_flit;
        logic [3:0] e_plen;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(bit rst, logic [1:0] v, logic lr, logic [3:0] l0, logic [3:0] l1,
                                 logic [1:0] er, logic ev, int src, int fl, logic [3:0] pl,
                                 logic ee);
        vec_t r;
        r.rst = rst; r.v = v; r.lr = lr; r.len0 = l0; r.len1 = l1;
        r.e_ready = er; r.e_v = ev; r.e_src = src; r.e_flit = fl; r.e_plen = pl; r.e_err = ee;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] mk(logic [255:0] b, logic [3:0] len);
        logic [255:0] r;
        r = b;
        r[10:7] = len;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last = 1;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        v_i = 2'b11;
        link_ready_i = 1'b1;
        #2;
        chk("rst_link_v", 64'(link_v_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_len_err", 64'(len_err_o), 64'd0);
        model_reset();
        @(posedge clk);
        #2;
        v_i = 2'b00;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive, sample, check against the model, then advance the model.
    task automatic step(input logic [1:0] v, input logic lr, output logic [1:0] g_r,
                        output logic g_v, output logic [63:0] g_d, output logic g_e);
        logic [1:0]   e_r;
        logic         e_v;
        logic [63:0]  e_d;
        logic [255:0] pk[2];
        logic [3:0]   lenv;
        int           w;
        bit           win;
        v_i = v;
        link_ready_i = lr;
        packet_i = {pk1, pk0};
        pk[0] = pk0;
        pk[1] = pk1;
        #1;
        g_r = ready_o; g_v = link_v_o; g_d = link_data_o; g_e = len_err_o;
        e_v = (m_q.size() != 0);
        e_d = e_v ? m_q[0] : 64'd0;
        win = (m_q.size() == 0) || (lr && m_q.size() == 1);
        w = -1;
        if (win) begin
            for (int k = 1; k <= 2; k++) begin
                int idx;
                idx = (m_last + k) % 2;
                if (w < 0 && v[idx]) w = idx;
            end
        end
        e_r = 2'b00;
        if (w >= 0) e_r[w] = 1'b1;
        chk("model_ready", 64'(g_r), 64'(e_r));
        chk("model_link_v", 64'(g_v), 64'(e_v));
        if (e_v) chk("model_data", g_d, e_d);
        chk("model_len_err", 64'(g_e), 64'(m_err));
        @(posedge clk);
        if (e_v && lr) void'(m_q.pop_front());
        if (w >= 0) begin
            lenv = pk[w][10:7];
            if (lenv > 4'd3) begin
                m_err = 1'b1;
                lenv = 4'd3;
            end
            for (int f = 0; f <= int'(lenv); f++) m_q.push_back(pk[w][f*64 +: 64]);
            m_last = w;
        end
        #1;
    endtask

    initial begin
        logic [1:0]   g_r;
        logic         g_v, g_e;
        logic [63:0]  g_d;
        logic [255:0] exp_pkt;

        base0 = rnd256();
        base1 = rnd256();
        model_reset();

        // Single source, len=3, ready held high.
        tbl.push_back(row(1, 2'b01, 1, 3, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 0, 3, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 1, 3, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 2, 3, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 3, 3, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 0, 0, 0, 0, 0));
        // Both sources, len=0: alternating grants, no bubbles.
        tbl.push_back(row(1, 2'b11, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b11, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b11, 1, 0, 0, 2'b01, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 2'b11, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 1, 0, 0, 2'b00, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        // len=1 with backpressure on cycles 1-3.
        tbl.push_back(row(1, 2'b01, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 0, 1, 0, 2'b00, 1, 0, 0, 1, 0));
        tbl.push_back(row(0, 2'b00, 0, 1, 0, 2'b00, 1, 0, 0, 1, 0));
        tbl.push_back(row(0, 2'b00, 0, 1, 0, 2'b00, 1, 0, 0, 1, 0));
        tbl.push_back(row(0, 2'b00, 1, 1, 0, 2'b00, 1, 0, 0, 1, 0));
        tbl.push_back(row(0, 2'b00, 1, 1, 0, 2'b00, 1, 0, 1, 1, 0));
        tbl.push_back(row(0, 2'b00, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
        // len field 15: clamped to 4 flits, sticky error.
        tbl.push_back(row(1, 2'b01, 1, 15, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 1, 15, 0, 2'b00, 1, 0, 0, 15, 1));
        tbl.push_back(row(0, 2'b00, 1, 15, 0, 2'b00, 1, 0, 1, 15, 1));
        tbl.push_back(row(0, 2'b00, 1, 15, 0, 2'b00, 1, 0, 2, 15, 1));
        tbl.push_back(row(0, 2'b00, 1, 15, 0, 2'b00, 1, 0, 3, 15, 1));
        tbl.push_back(row(0, 2'b01, 1, 0, 0, 2'b01, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        // One-cycle pulse on source 1 during a packet is never granted.
        tbl.push_back(row(1, 2'b01, 1, 3, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b10, 1, 3, 0, 2'b00, 1, 0, 0, 3, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 1, 3, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 2, 3, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 1, 0, 3, 3, 0));
        tbl.push_back(row(0, 2'b00, 1, 3, 0, 2'b00, 0, 0, 0, 0, 0));

        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            pk0 = mk(base0, tbl[i].len0);
            pk1 = mk(base1, tbl[i].len1);
            step(tbl[i].v, tbl[i].lr, g_r, g_v, g_d, g_e);
            chk($sformatf("tbl%0d_ready", i), 64'(g_r), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_link_v", i), 64'(g_v), 64'(tbl[i].e_v));
            chk($sformatf("tbl%0d_len_err", i), 64'(g_e), 64'(tbl[i].e_err));
            if (tbl[i].e_v) begin
                exp_pkt = mk((tbl[i].e_src == 1) ? base1 : base0, tbl[i].e_plen);
                chk($sformatf("tbl%0d_data", i), g_d, exp_pkt[tbl[i].e_flit*64 +: 64]);
            end
        end

        // Asynchronous reset during flit 2 of a len=3 packet.
        do_reset();
        pk0 = mk(base0, 3);
        pk1 = mk(base1, 0);
        step(2'b01, 1'b1, g_r, g_v, g_d, g_e);
        step(2'b00, 1'b1, g_r, g_v, g_d, g_e);
        step(2'b00, 1'b1, g_r, g_v, g_d, g_e);
        v_i = 2'b11;
        #2;
        chk("mid_pkt_link_v", 64'(link_v_o), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_link_v", 64'(link_v_o), 64'd0);
        chk("async_rst_ready", 64'(ready_o), 64'd0);
        model_reset();
        v_i = 2'b00;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(2'b11, 1'b1, g_r, g_v, g_d, g_e);
        chk("post_rst_priority", 64'(g_r), 64'b01);
        step(2'b00, 1'b1, g_r, g_v, g_d, g_e);
        chk("post_rst_head", g_d, pk0[63:0]);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pk0 = mk(rnd256(), ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                           : 4'($urandom_range(0, 3)));
            pk1 = mk(rnd256(), ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                           : 4'($urandom_range(0, 3)));
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), g_r, g_v, g_d, g_e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
